// File: rtl/cabac_bin_dec_engine_pkg.sv
// +----------------------------------------------------------------------------
// | cabac_bin_dec_engine_pkg: shared rangeLPS table, mode/state encodings and
// | the renormalisation shift helper for the CABAC bin decoder.  Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package cabac_bin_dec_engine_pkg;

    localparam logic [1:0] MODE_REGULAR   = 2'd0;
    localparam logic [1:0] MODE_BYPASS    = 2'd1;
    localparam logic [1:0] MODE_TERMINATE = 2'd2;

    localparam logic [8:0] INIT_RANGE = 9'd510;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } dec_state_e;

    localparam logic [7:0] RANGE_LPS_TAB [64][4] = '{
        '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216}, '{123,150,178,205},
        '{116,142,169,195}, '{111,135,160,185}, '{105,128,152,175}, '{100,122,144,166},
        '{ 95,116,137,158}, '{ 90,110,130,150}, '{ 85,104,123,142}, '{ 81, 99,117,135},
        '{ 77, 94,111,128}, '{ 73, 89,105,122}, '{ 69, 85,100,116}, '{ 66, 80, 95,110},
        '{ 62, 76, 90,104}, '{ 59, 72, 86, 99}, '{ 56, 69, 81, 94}, '{ 53, 65, 77, 89},
        '{ 51, 62, 73, 85}, '{ 48, 59, 69, 80}, '{ 46, 56, 66, 76}, '{ 43, 53, 63, 72},
        '{ 41, 50, 59, 69}, '{ 39, 48, 56, 65}, '{ 37, 45, 54, 62}, '{ 35, 43, 51, 59},
        '{ 33, 41, 48, 56}, '{ 32, 39, 46, 53}, '{ 30, 37, 43, 50}, '{ 29, 35, 41, 48},
        '{ 27, 33, 39, 45}, '{ 26, 31, 37, 43}, '{ 24, 30, 35, 41}, '{ 23, 28, 33, 39},
        '{ 22, 27, 32, 37}, '{ 21, 26, 30, 35}, '{ 20, 24, 29, 33}, '{ 19, 23, 27, 31},
        '{ 18, 22, 26, 30}, '{ 17, 21, 25, 28}, '{ 16, 20, 23, 27}, '{ 15, 19, 22, 25},
        '{ 14, 18, 21, 24}, '{ 14, 17, 20, 23}, '{ 13, 16, 19, 22}, '{ 12, 15, 18, 21},
        '{ 12, 14, 17, 20}, '{ 11, 14, 16, 19}, '{ 11, 13, 15, 18}, '{ 10, 12, 15, 17},
        '{ 10, 12, 14, 16}, '{  9, 11, 13, 15}, '{  9, 11, 12, 14}, '{  8, 10, 12, 14},
        '{  8,  9, 11, 13}, '{  7,  9, 11, 12}, '{  7,  9, 10, 12}, '{  7,  8, 10, 11},
        '{  6,  8,  9, 11}, '{  6,  7,  9, 10}, '{  6,  7,  8,  9}, '{  2,  2,  2,  2}
    };

    // Leading-zero count of a 9-bit range, saturated at the 6-bit maximum shift.
    function automatic logic [2:0] renorm_shift(input logic [8:0] r);
        logic [2:0] n;
        casez (r)
            9'b1????????: n = 3'd0;
            9'b01???????: n = 3'd1;
            9'b001??????: n = 3'd2;
            9'b0001?????: n = 3'd3;
            9'b00001????: n = 3'd4;
            9'b000001???: n = 3'd5;
            default:      n = 3'd6;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cabac_bin_dec_lut.sv
// +----------------------------------------------------------------------------
// | cabac_bin_dec_lut: rangeLPS lookup plus the LPS-path renormalisation shift.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module cabac_bin_dec_lut
    import cabac_bin_dec_engine_pkg::*;
(
    input  logic [5:0] state_i,
    input  logic [1:0] q_i,
    output logic [7:0] rlps_o,
    output logic [2:0] shift_o
);

    assign rlps_o  = RANGE_LPS_TAB[state_i][q_i];
    assign shift_o = renorm_shift({1'b0, rlps_o});

endmodule

`default_nettype wire

// File: rtl/cabac_bin_dec_engine.sv
// +----------------------------------------------------------------------------
// | cabac_bin_dec_engine: CABAC binary arithmetic decoder (regular/bypass/term).
// | Optional CABAC_DEC_BIN_CNT_EN adds a 32-bit emitted-bin counter. Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module cabac_bin_dec_engine
    import cabac_bin_dec_engine_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_mode_i,
    input  logic [5:0]  state_i,
    input  logic        mps_i,
    output logic        bin_valid_o,
    output logic        bin_o,
    output logic        bin_eq_lps_o,
    output logic        done_o,
    output logic [8:0]  range_o,
    output logic [8:0]  offset_o
`ifdef CABAC_DEC_BIN_CNT_EN
    ,
    output logic [31:0] bin_cnt_o
`endif
);

    dec_state_e  state_q, state_d;
    logic [8:0]  range_q, range_d;
    logic [8:0]  offset_q, offset_d;
    logic [15:0] buf_q, buf_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        bin_valid_q, bin_valid_d;
    logic        bin_q, bin_d;
    logic        lps_q, lps_d;

    logic [7:0]  w_rlps;
    logic [2:0]  w_lps_shift;
    logic [8:0]  w_rm;
    logic        w_req_fire;
    logic        w_renorm;
    logic [2:0]  w_n;
    logic [3:0]  w_k;
    logic [8:0]  w_rr;
    logic [8:0]  w_oo;
    logic [9:0]  w_byp;
    logic [4:0]  w_rem;
    logic [15:0] w_buf;

    cabac_bin_dec_lut u_lut (
        .state_i (state_i),
        .q_i     (range_q[7:6]),
        .rlps_o  (w_rlps),
        .shift_o (w_lps_shift)
    );

    assign w_rm = range_q - {1'b0, w_rlps};

    always_comb begin
        state_d      = state_q;
        range_d      = range_q;
        offset_d     = offset_q;
        bin_valid_d  = 1'b0;
        bin_d        = bin_q;
        lps_d        = lps_q;
        w_renorm     = 1'b0;
        w_n          = 3'd0;
        w_k          = 4'd0;
        w_rr         = range_q;
        w_oo         = offset_q;
        w_byp        = {offset_q, buf_q[15]};
        req_ready_o  = !start_i && (state_q == ST_RUN) && (cnt_q >= 5'd6);
        w_req_fire   = req_ready_o && req_valid_i;

        case (state_q)
            ST_INIT: begin
                if (cnt_q >= 5'd9) begin
                    offset_d = buf_q[15:7];
                    w_k      = 4'd9;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_req_fire) begin
                    bin_valid_d = 1'b1;
                    lps_d       = 1'b0;
                    case (req_mode_i)
                        MODE_REGULAR: begin
                            w_renorm = 1'b1;
                            if (offset_q >= w_rm) begin
                                bin_d = !mps_i;
                                lps_d = 1'b1;
                                w_oo  = offset_q - w_rm;
                                w_rr  = {1'b0, w_rlps};
                                w_n   = w_lps_shift;
                            end else begin
                                bin_d = mps_i;
                                w_rr  = w_rm;
                                w_n   = renorm_shift(w_rm);
                            end
                        end
                        MODE_TERMINATE: begin
                            w_rr = range_q - 9'd2;
                            if (offset_q >= w_rr) begin
                                bin_d   = 1'b1;
                                range_d = w_rr;
                                state_d = ST_DONE;
                            end else begin
                                bin_d    = 1'b0;
                                w_renorm = 1'b1;
                                w_n      = renorm_shift(w_rr);
                            end
                        end
                        default: begin
                            // Reserved mode decodes as bypass.
                            w_k = 4'd1;
                            if (w_byp >= {1'b0, range_q}) begin
                                bin_d    = 1'b1;
                                offset_d = 9'(w_byp - {1'b0, range_q});
                            end else begin
                                bin_d    = 1'b0;
                                offset_d = w_byp[8:0];
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase

        if (w_renorm) begin
            range_d  = w_rr << w_n;
            offset_d = (w_oo << w_n) | {3'b000, buf_q[15:10] >> (3'd6 - w_n)};
            w_k      = {1'b0, w_n};
        end

        // Consume first, then the incoming byte lands directly below what is left.
        w_buf        = buf_q << w_k;
        w_rem        = cnt_q - {1'b0, w_k};
        byte_ready_o = !start_i && ((state_q == ST_INIT) || (state_q == ST_RUN))
                       && (w_rem <= 5'd8);
        if (byte_ready_o && byte_valid_i) begin
            w_buf = w_buf | ({byte_i, 8'h00} >> w_rem);
            w_rem = w_rem + 5'd8;
        end
        buf_d = w_buf;
        cnt_d = w_rem;

        if (start_i) begin
            state_d     = ST_INIT;
            range_d     = INIT_RANGE;
            offset_d    = 9'd0;
            buf_d       = 16'd0;
            cnt_d       = 5'd0;
            bin_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            range_q     <= 9'd0;
            offset_q    <= 9'd0;
            buf_q       <= 16'd0;
            cnt_q       <= 5'd0;
            bin_valid_q <= 1'b0;
            bin_q       <= 1'b0;
            lps_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            range_q     <= range_d;
            offset_q    <= offset_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            bin_valid_q <= bin_valid_d;
            bin_q       <= bin_d;
            lps_q       <= lps_d;
        end
    end

`ifdef CABAC_DEC_BIN_CNT_EN
    logic [31:0] bin_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt_q <= 32'd0;
        end else if (start_i) begin
            bin_cnt_q <= 32'd0;
        end else if (bin_valid_d) begin
            bin_cnt_q <= bin_cnt_q + 32'd1;
        end
    end

    assign bin_cnt_o = bin_cnt_q;
`endif

    assign bin_valid_o  = bin_valid_q;
    assign bin_o        = bin_q;
    assign bin_eq_lps_o = lps_q;
    assign done_o       = (state_q == ST_DONE);
    assign range_o      = range_q;
    assign offset_o     = offset_q;

endmodule

`default_nettype wire

// File: tb/tb_cabac_bin_dec_engine.sv
// +----------------------------------------------------------------------------
// | tb_cabac_bin_dec_engine: directed and randomized bench for the CABAC bin
// | decoder against a bit-queue arithmetic-decoding model. Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_cabac_bin_dec_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_ready_o;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_mode_i = 2'd0;
    logic [5:0]  state_i = 6'd0;
    logic        mps_i = 1'b0;
    logic        bin_valid_o;
    logic        bin_o;
    logic        bin_eq_lps_o;
    logic        done_o;
    logic [8:0]  range_o;
    logic [8:0]  offset_o;
`ifdef CABAC_DEC_BIN_CNT_EN
    logic [31:0] bin_cnt_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    int byte_q[$];
    int m_bits[$];
    int m_range;
    int m_offset;

    int LPS_TAB [64][4] = '{
        '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216}, '{123,150,178,205},
        '{116,142,169,195}, '{111,135,160,185}, '{105,128,152,175}, '{100,122,144,166},
        '{ 95,116,137,158}, '{ 90,110,130,150}, '{ 85,104,123,142}, '{ 81, 99,117,135},
        '{ 77, 94,111,128}, '{ 73, 89,105,122}, '{ 69, 85,100,116}, '{ 66, 80, 95,110},
        '{ 62, 76, 90,104}, '{ 59, 72, 86, 99}, '{ 56, 69, 81, 94}, '{ 53, 65, 77, 89},
        '{ 51, 62, 73, 85}, '{ 48, 59, 69, 80}, '{ 46, 56, 66, 76}, '{ 43, 53, 63, 72},
        '{ 41, 50, 59, 69}, '{ 39, 48, 56, 65}, '{ 37, 45, 54, 62}, '{ 35, 43, 51, 59},
        '{ 33, 41, 48, 56}, '{ 32, 39, 46, 53}, '{ 30, 37, 43, 50}, '{ 29, 35, 41, 48},
        '{ 27, 33, 39, 45}, '{ 26, 31, 37, 43}, '{ 24, 30, 35, 41}, '{ 23, 28, 33, 39},
        '{ 22, 27, 32, 37}, '{ 21, 26, 30, 35}, '{ 20, 24, 29, 33}, '{ 19, 23, 27, 31},
        '{ 18, 22, 26, 30}, '{ 17, 21, 25, 28}, '{ 16, 20, 23, 27}, '{ 15, 19, 22, 25},
        '{ 14, 18, 21, 24}, '{ 14, 17, 20, 23}, '{ 13, 16, 19, 22}, '{ 12, 15, 18, 21},
        '{ 12, 14, 17, 20}, '{ 11, 14, 16, 19}, '{ 11, 13, 15, 18}, '{ 10, 12, 15, 17},
        '{ 10, 12, 14, 16}, '{  9, 11, 13, 15}, '{  9, 11, 12, 14}, '{  8, 10, 12, 14},
        '{  8,  9, 11, 13}, '{  7,  9, 11, 12}, '{  7,  9, 10, 12}, '{  7,  8, 10, 11},
        '{  6,  8,  9, 11}, '{  6,  7,  9, 10}, '{  6,  7,  8,  9}, '{  2,  2,  2,  2}
    };

    cabac_bin_dec_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_mode_i   (req_mode_i),
        .state_i      (state_i),
        .mps_i        (mps_i),
        .bin_valid_o  (bin_valid_o),
        .bin_o        (bin_o),
        .bin_eq_lps_o (bin_eq_lps_o),
        .done_o       (done_o),
        .range_o      (range_o),
        .offset_o     (offset_o)
`ifdef CABAC_DEC_BIN_CNT_EN
        ,
        .bin_cnt_o    (bin_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Byte source: offers the queue head every cycle and pops it on a handshake.
    initial begin : byte_feeder
        bit fire;
        forever begin
            @(negedge clk);
            if (byte_q.size() > 0) begin
                byte_valid_i = 1'b1;
                byte_i       = 8'(byte_q[0]);
            end else begin
                byte_valid_i = 1'b0;
            end
            #4;
            fire = byte_valid_i && byte_ready_o;
            @(posedge clk);
            if (fire && byte_q.size() > 0) void'(byte_q.pop_front());
        end
    end

    function automatic void push_byte(input int b);
        byte_q.push_back(b);
        for (int i = 7; i >= 0; i--) m_bits.push_back((b >> i) & 1);
    endfunction

    function automatic int getbit();
        if (m_bits.size() == 0) return 0;
        return m_bits.pop_front();
    endfunction

    function automatic void model_init();
        m_range  = 510;
        m_offset = 0;
        for (int i = 0; i < 9; i++) m_offset = m_offset * 2 + getbit();
    endfunction

    function automatic void model_bin(input int mode, input int st, input int mps,
                                      output int bin, output int lps, output int done);
        int rlps, rm;
        bin = 0; lps = 0; done = 0;
        if (mode == 0) begin
            rlps = LPS_TAB[st][(m_range >> 6) & 3];
            rm   = m_range - rlps;
            if (m_offset >= rm) begin
                bin = 1 - mps; lps = 1; m_offset = m_offset - rm; m_range = rlps;
            end else begin
                bin = mps; m_range = rm;
            end
            while (m_range < 256) begin
                m_range  = m_range * 2;
                m_offset = m_offset * 2 + getbit();
            end
        end else if (mode == 2) begin
            m_range = m_range - 2;
            if (m_offset >= m_range) begin
                bin = 1; done = 1;
            end else begin
                while (m_range < 256) begin
                    m_range  = m_range * 2;
                    m_offset = m_offset * 2 + getbit();
                end
            end
        end else begin
            m_offset = m_offset * 2 + getbit();
            if (m_offset >= m_range) begin
                bin = 1; m_offset = m_offset - m_range;
            end
        end
    endfunction

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        byte_q.delete();
        m_bits.delete();
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Presents one request and waits (bounded) for its acceptance; returns at accept edge + 1.
    task automatic req(input int mode, input int st, input int mps, output bit ok);
        bit rdy;
        ok = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_mode_i  = 2'(mode);
        state_i     = 6'(st);
        mps_i       = 1'(mps);
        for (int c = 0; c < 64; c++) begin
            #4 rdy = req_ready_o;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bin_valid_o, bin_o, bin_eq_lps_o, done_o, range_o, offset_o, req_ready_o, byte_ready_o} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_values: got valid=%b bin=%b lps=%b done=%b range=%0d offset=%0d rr=%b br=%b, want all 0",
                     bin_valid_o, bin_o, bin_eq_lps_o, done_o, range_o, offset_o, req_ready_o, byte_ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (req_ready_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: got req_ready=%b byte_ready=%b, want 0 0", req_ready_o, byte_ready_o);
        end
    endtask

    task automatic test_init_mps();
        bit ok;
        do_start();
        push_byte(8'h00); push_byte(8'h00);
        req(0, 0, 0, ok);
        vectors++;
        if (!ok || bin_valid_o !== 1'b1 || bin_o !== 1'b0 || bin_eq_lps_o !== 1'b0 || range_o !== 9'd270 || offset_o !== 9'd0) begin
            miscompares++;
            $display("FAIL init_mps: got ok=%b v=%b bin=%b lps=%b range=%0d offset=%0d, want 1 1 0 0 270 0",
                     ok, bin_valid_o, bin_o, bin_eq_lps_o, range_o, offset_o);
        end
        @(posedge clk); #1;
        vectors++;
        if (bin_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bin_valid_pulse: got %b, want 0", bin_valid_o);
        end
    endtask

    task automatic test_lps_renorm();
        bit ok;
        do_start();
        push_byte(8'hFE); push_byte(8'h00);
        req(0, 0, 1, ok);
        vectors++;
        if (!ok || bin_valid_o !== 1'b1 || bin_o !== 1'b0 || bin_eq_lps_o !== 1'b1 || range_o !== 9'd480 || offset_o !== 9'd476) begin
            miscompares++;
            $display("FAIL lps_renorm: got ok=%b v=%b bin=%b lps=%b range=%0d offset=%0d, want 1 1 0 1 480 476",
                     ok, bin_valid_o, bin_o, bin_eq_lps_o, range_o, offset_o);
        end
    endtask

    task automatic test_bypass();
        bit ok;
        do_start();
        push_byte(8'hFE); push_byte(8'h00);
        req(1, 0, 0, ok);
        vectors++;
        if (!ok || bin_o !== 1'b1 || bin_eq_lps_o !== 1'b0 || range_o !== 9'd510 || offset_o !== 9'd506) begin
            miscompares++;
            $display("FAIL bypass: got ok=%b bin=%b lps=%b range=%0d offset=%0d, want 1 1 0 510 506",
                     ok, bin_o, bin_eq_lps_o, range_o, offset_o);
        end
    endtask

    task automatic test_terminate();
        bit ok;
        do_start();
        push_byte(8'hFE); push_byte(8'h00);
        req(2, 0, 0, ok);
        vectors++;
        if (!ok || bin_o !== 1'b1 || done_o !== 1'b1 || range_o !== 9'd508 || bin_eq_lps_o !== 1'b0) begin
            miscompares++;
            $display("FAIL terminate_one: got ok=%b bin=%b done=%b range=%0d lps=%b, want 1 1 1 508 0",
                     ok, bin_o, done_o, range_o, bin_eq_lps_o);
        end
        push_byte(8'h55);
        req(0, 0, 0, ok);
        vectors++;
        if (ok || byte_ready_o !== 1'b0 || done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL done_blocks: got accepted=%b byte_ready=%b done=%b, want 0 0 1", ok, byte_ready_o, done_o);
        end
        do_start();
        push_byte(8'h00); push_byte(8'h00);
        req(2, 0, 0, ok);
        vectors++;
        if (!ok || bin_o !== 1'b0 || done_o !== 1'b0 || range_o !== 9'd508) begin
            miscompares++;
            $display("FAIL terminate_zero: got ok=%b bin=%b done=%b range=%0d, want 1 0 0 508",
                     ok, bin_o, done_o, range_o);
        end
        req(1, 0, 0, ok);
        vectors++;
        if (!ok || bin_o !== 1'b0) begin
            miscompares++;
            $display("FAIL terminate_stays_run: got ok=%b bin=%b, want 1 0", ok, bin_o);
        end
    endtask

    task automatic test_starvation();
        bit seen;
        do_start();
        push_byte(8'h12);
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (req_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL starved_ready: got %b, want 0", req_ready_o);
        end
        push_byte(8'h34);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            seen = req_ready_o;
        end
        vectors++;
        if (!seen || offset_o !== 9'd36 || range_o !== 9'd510) begin
            miscompares++;
            $display("FAIL starved_resume: got ready=%b offset=%0d range=%0d, want 1 36 510", seen, offset_o, range_o);
        end
    endtask

    task automatic test_random(input int nbins);
        bit ok;
        int mode, st, mps, bin, lps, done;
        do_start();
        push_byte($urandom_range(0, 254));
        for (int i = 0; i < 140; i++) push_byte($urandom_range(0, 255));
        model_init();
        for (int i = 0; i < nbins; i++) begin
            mode = $urandom_range(0, 3);
            if (mode == 2 && $urandom_range(0, 7) != 0) mode = 0;
            st  = $urandom_range(0, 62);
            mps = $urandom_range(0, 1);
            req(mode, st, mps, ok);
            model_bin(mode, st, mps, bin, lps, done);
            vectors++;
            if (!ok || bin_valid_o !== 1'b1 || bin_o !== bin[0] || bin_eq_lps_o !== lps[0] ||
                range_o !== m_range[8:0] || offset_o !== m_offset[8:0] || done_o !== done[0]) begin
                miscompares++;
                $display("FAIL random_bin[%0d] mode=%0d st=%0d mps=%0d: got ok=%b v=%b bin=%b lps=%b range=%0d offset=%0d done=%b, want bin=%0d lps=%0d range=%0d offset=%0d done=%0d",
                         i, mode, st, mps, ok, bin_valid_o, bin_o, bin_eq_lps_o, range_o, offset_o, done_o,
                         bin, lps, m_range, m_offset, done);
                return;
            end
            if (done != 0) return;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit bad;
        do_start();
        push_byte($urandom_range(0, 254));
        for (int i = 0; i < 20; i++) push_byte($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) req(0, $urandom_range(0, 62), $urandom_range(0, 1), ok);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_mode_i  = 2'd0;
        #2;
        rst = 1'b1;
        byte_q.delete();
        m_bits.delete();
        #1;
        vectors++;
        if ({bin_valid_o, bin_o, bin_eq_lps_o, done_o, range_o, offset_o, req_ready_o, byte_ready_o} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got valid=%b bin=%b lps=%b done=%b range=%0d offset=%0d rr=%b br=%b, want all 0",
                     bin_valid_o, bin_o, bin_eq_lps_o, done_o, range_o, offset_o, req_ready_o, byte_ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #4;
            if (req_ready_o !== 1'b0 || bin_valid_o !== 1'b0) bad = 1'b1;
        end
        req_valid_i = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_idle: got req_ready or bin_valid high after reset, want 0");
        end
    endtask

    task automatic test_start_mid();
        bit ok;
        bit bad;
        do_start();
        for (int i = 0; i < 4; i++) push_byte(8'h00);
        req(0, 0, 0, ok);
        req(1, 0, 0, ok);
        @(negedge clk);
        start_i     = 1'b1;
        req_valid_i = 1'b1;
        req_mode_i  = 2'd2;
        byte_q.delete();
        m_bits.delete();
        @(posedge clk); #1;
        vectors++;
        if (bin_valid_o !== 1'b0 || range_o !== 9'd510 || offset_o !== 9'd0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL start_mid: got v=%b range=%0d offset=%0d done=%b, want 0 510 0 0",
                     bin_valid_o, range_o, offset_o, done_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #4;
            if (req_ready_o !== 1'b0) bad = 1'b1;
        end
        req_valid_i = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL start_flush: got req_ready high with empty buffer, want 0");
        end
        push_byte(8'h00); push_byte(8'h00);
        req(0, 0, 0, ok);
        vectors++;
        if (!ok || bin_o !== 1'b0 || range_o !== 9'd270 || offset_o !== 9'd0) begin
            miscompares++;
            $display("FAIL start_restart: got ok=%b bin=%b range=%0d offset=%0d, want 1 0 270 0",
                     ok, bin_o, range_o, offset_o);
        end
    endtask

    initial begin
        test_reset();
        test_init_mps();
        test_lps_renorm();
        test_bypass();
        test_terminate();
        test_starvation();
        for (int r = 0; r < 4; r++) test_random(120);
        test_reset_mid();
        test_start_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
